// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit: registered program-counter generator with return-address stack.
//
// Chooses the next fetch address with a fixed priority (reset, trap, mret,
// ALU redirect, stall, return prediction, sequential). A circular RAS
// provides call/return prediction, and misaligned redirect targets are
// rejected and reported for the trap logic.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_reset      synchronous active-high reset
//   i_stall      hold PC
//   i_trap       take trap this cycle
//   i_trap_vec   trap handler address (mtvec base)
//   i_mret       return from trap
//   i_mepc       return address for mret
//   i_pc_sel     redirect to the ALU-computed target
//   i_alu_data   redirect target
//   i_call       current instruction is a call
//   i_ret        current instruction is a return
//   o_pc         current fetch PC (registered)
//   o_pc_four    o_pc + 4 (combinational link value)
//   o_misalign   one-cycle pulse on a rejected misaligned redirect
//   o_bad_addr   captured misaligned target
//   o_ras_empty  RAS holds no valid entries
//   o_ras_full   RAS holds RAS_DEPTH entries
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     IALIGN       = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_pc_sel,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_call,
  input  logic            i_ret,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_four,
  output logic            o_misalign,
  output logic [XLEN-1:0] o_bad_addr,
  output logic            o_ras_empty,
  output logic            o_ras_full
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // Bits that must be zero in a legal instruction address.
  localparam logic [XLEN-1:0] LOW_BITS   = (IALIGN == 2) ? XLEN'(1) : XLEN'(3);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~LOW_BITS;
  localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(3);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

  // Architectural state.
  logic [XLEN-1:0]  pc_q;
  logic             misalign_q;
  logic [XLEN-1:0]  bad_addr_q;
  logic [PTR_W-1:0] ras_ptr_q;
  logic [CNT_W-1:0] ras_cnt_q;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];

  // Next-state values.
  logic [XLEN-1:0]  pc_d;
  logic             misalign_d;
  logic [XLEN-1:0]  bad_addr_d;
  logic [PTR_W-1:0] ras_ptr_d;
  logic [CNT_W-1:0] ras_cnt_d;

  logic [XLEN-1:0]  pc_four;
  logic             ras_empty;
  logic             ras_full;
  logic [PTR_W-1:0] top_idx;
  logic [XLEN-1:0]  ras_top;
  logic             target_misaligned;
  logic             ras_en;
  logic             do_push;
  logic             do_pop;
  logic             ras_we;
  logic [PTR_W-1:0] ras_widx;

  // Link value and RAS status.
  always_comb begin
    pc_four   = pc_q + XLEN'(4);
    ras_empty = (ras_cnt_q == '0);
    ras_full  = (ras_cnt_q == CNT_FULL);
    // ras_ptr_q names the next free slot; the top sits one below it.
    top_idx   = ras_ptr_q - PTR_W'(1);
    ras_top   = ras_mem[top_idx];
    target_misaligned = (i_alu_data & LOW_BITS) != '0;
  end

  // RAS control: trap, mret and stall freeze the stack; a redirect does not.
  always_comb begin
    ras_en    = !i_trap && !i_mret && !i_stall;
    do_pop    = ras_en && i_ret && !ras_empty;
    do_push   = ras_en && i_call;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_widx  = ras_ptr_q;
    unique case ({do_push, do_pop})
      2'b10: begin
        // Push; when full the oldest entry is overwritten circularly.
        ras_we    = 1'b1;
        ras_widx  = ras_ptr_q;
        ras_ptr_d = ras_ptr_q + PTR_W'(1);
        if (!ras_full) begin
          ras_cnt_d = ras_cnt_q + CNT_W'(1);
        end
      end
      2'b01: begin
        ras_ptr_d = top_idx;
        ras_cnt_d = ras_cnt_q - CNT_W'(1);
      end
      2'b11: begin
        // Pop then push: replace the top in place.
        ras_we   = 1'b1;
        ras_widx = top_idx;
      end
      default: ;
    endcase
  end

  // Next-PC selection in priority order.
  always_comb begin
    pc_d       = pc_four;
    misalign_d = 1'b0;
    bad_addr_d = bad_addr_q;
    if (i_trap) begin
      pc_d = i_trap_vec & WORD_MASK;
    end else if (i_mret) begin
      pc_d = i_mepc & ALIGN_MASK;
    end else if (i_pc_sel) begin
      if (target_misaligned) begin
        pc_d       = pc_q;
        misalign_d = 1'b1;
        bad_addr_d = i_alu_data;
      end else begin
        pc_d = i_alu_data;
      end
    end else if (i_stall) begin
      pc_d = pc_q;
    end else if (i_ret && !ras_empty) begin
      pc_d = ras_top;
    end
  end

  // Control and PC registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
      ras_ptr_q  <= '0;
      ras_cnt_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
      ras_ptr_q  <= ras_ptr_d;
      ras_cnt_q  <= ras_cnt_d;
    end
  end

  // RAS storage; contents survive reset, only pointer and count clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset && ras_we) begin
      ras_mem[ras_widx] <= pc_four;
    end
  end

  assign o_pc        = pc_q;
  assign o_pc_four   = pc_four;
  assign o_misalign  = misalign_q;
  assign o_bad_addr  = bad_addr_q;
  assign o_ras_empty = ras_empty;
  assign o_ras_full  = ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit: directed bench for pc_unit. Two instances share stimulus:
// dut (IALIGN=4) and dut2 (IALIGN=2), so alignment-dependent behaviour can
// be compared side by side. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, trap, mret, pc_sel, call, ret;
  logic [31:0] trap_vec, mepc, alu_data;

  logic [31:0] pc, pc_four, bad_addr;
  logic        misalign, ras_empty, ras_full;
  logic [31:0] pc2, pc_four2, bad_addr2;
  logic        misalign2, ras_empty2, ras_full2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4), .RAS_DEPTH(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_trap(trap),
    .i_trap_vec(trap_vec), .i_mret(mret), .i_mepc(mepc), .i_pc_sel(pc_sel),
    .i_alu_data(alu_data), .i_call(call), .i_ret(ret),
    .o_pc(pc), .o_pc_four(pc_four), .o_misalign(misalign),
    .o_bad_addr(bad_addr), .o_ras_empty(ras_empty), .o_ras_full(ras_full)
  );

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(2), .RAS_DEPTH(4)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_trap(trap),
    .i_trap_vec(trap_vec), .i_mret(mret), .i_mepc(mepc), .i_pc_sel(pc_sel),
    .i_alu_data(alu_data), .i_call(call), .i_ret(ret),
    .o_pc(pc2), .o_pc_four(pc_four2), .o_misalign(misalign2),
    .o_bad_addr(bad_addr2), .o_ras_empty(ras_empty2), .o_ras_full(ras_full2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; trap = 0; mret = 0; pc_sel = 0; call = 0; ret = 0;
  endtask

  initial begin
    idle();
    reset = 1; trap_vec = '0; mepc = '0; alu_data = '0;

    // Reset for two cycles, then free-run.
    cycle();
    check("rst_pc", pc, 32'h0);
    check("rst_empty", 32'(ras_empty), 32'h1);
    check("rst_full", 32'(ras_full), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_bad", bad_addr, 32'h0);
    cycle();
    check("rst_pc2", pc, 32'h0);
    reset = 0;
    cycle(); check("seq_4", pc, 32'h4);
    cycle(); check("seq_8", pc, 32'h8);
    cycle(); check("seq_c", pc, 32'hC);
    check("pc_four_c", pc_four, 32'h10);
    cycle(); check("seq_10", pc, 32'h10);

    // Aligned redirect, then 3-cycle stall.
    pc_sel = 1; alu_data = 32'h200;
    cycle(); pc_sel = 0;
    check("redir_200", pc, 32'h200);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(); check("stall_hold", pc, 32'h200);
    end
    stall = 0;
    cycle(); check("after_stall", pc, 32'h204);

    // Stall blocks a call from touching the RAS.
    stall = 1; call = 1;
    cycle(); stall = 0; call = 0;
    check("stall_call_pc", pc, 32'h204);
    check("stall_call_empty", 32'(ras_empty), 32'h1);

    // Misaligned redirect: IALIGN=4 rejects, IALIGN=2 accepts.
    pc_sel = 1; alu_data = 32'h40;
    cycle(); check("to_40", pc, 32'h40);
    alu_data = 32'h102;
    cycle(); pc_sel = 0;
    check("mis_pc", pc, 32'h40);
    check("mis_flag", 32'(misalign), 32'h1);
    check("mis_bad", bad_addr, 32'h102);
    check("mis2_pc", pc2, 32'h102);
    check("mis2_flag", 32'(misalign2), 32'h0);
    trap = 1; trap_vec = 32'h1001;
    cycle(); trap = 0;
    check("trap_pc", pc, 32'h1000);
    check("trap_pc2", pc2, 32'h1000);
    check("mis_clear", 32'(misalign), 32'h0);
    check("bad_hold", bad_addr, 32'h102);

    // mret alignment depends on IALIGN.
    mret = 1; mepc = 32'h503;
    cycle(); mret = 0;
    check("mret_pc", pc, 32'h500);
    check("mret_pc2", pc2, 32'h502);

    // Call with simultaneous redirect, then return.
    pc_sel = 1; alu_data = 32'h100;
    cycle(); check("to_100", pc, 32'h100);
    call = 1; alu_data = 32'h300;
    cycle(); call = 0; pc_sel = 0;
    check("call_pc", pc, 32'h300);
    check("call_nonempty", 32'(ras_empty), 32'h0);
    cycle(); check("seq_304", pc, 32'h304);
    ret = 1;
    cycle(); check("ret_pc", pc, 32'h104);
    check("ret_empty", 32'(ras_empty), 32'h1);
    cycle(); ret = 0;
    check("ret_empty_fall", pc, 32'h108);

    // Overflow: five calls into a four-entry stack.
    pc_sel = 1; alu_data = 32'h0;
    cycle(); check("to_0", pc, 32'h0);
    call = 1;
    for (int i = 0; i < 5; i++) begin
      alu_data = (i == 4) ? 32'h600 : 32'((i + 1) * 16);
      cycle();
    end
    call = 0; pc_sel = 0;
    check("ovf_pc", pc, 32'h600);
    check("ovf_full", 32'(ras_full), 32'h1);
    ret = 1;
    cycle(); check("pop_44", pc, 32'h44);
    check("pop_notfull", 32'(ras_full), 32'h0);
    cycle(); check("pop_34", pc, 32'h34);
    cycle(); check("pop_24", pc, 32'h24);
    cycle(); check("pop_14", pc, 32'h14);
    check("pop_empty", 32'(ras_empty), 32'h1);
    ret = 0;

    // Call and return together replace the top in place.
    pc_sel = 1; alu_data = 32'h10;
    cycle(); check("to_10", pc, 32'h10);
    call = 1; alu_data = 32'h80;
    cycle(); pc_sel = 0;
    check("to_80", pc, 32'h80);
    ret = 1;
    cycle(); call = 0; ret = 0;
    check("callret_pc", pc, 32'h14);
    check("callret_cnt", 32'(ras_empty), 32'h0);
    cycle(); check("seq_18", pc, 32'h18);
    ret = 1;
    cycle(); ret = 0;
    check("replaced_top", pc, 32'h84);
    check("replaced_empty", 32'(ras_empty), 32'h1);

    // Trap beats mret.
    trap = 1; trap_vec = 32'h2000; mret = 1; mepc = 32'h3000;
    cycle(); trap = 0; mret = 0;
    check("trap_mret", pc, 32'h2000);

    // pc_four wrap at the top of the address space.
    pc_sel = 1; alu_data = 32'hFFFF_FFFC;
    cycle(); pc_sel = 0;
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("wrap_four", pc_four, 32'h0);
    cycle(); check("wrap_pc", pc, 32'h0);

    // Reset beats redirect and clears misalign state.
    pc_sel = 1; alu_data = 32'h103;
    cycle(); check("mis2_flag_b", 32'(misalign), 32'h1);
    alu_data = 32'h400; reset = 1; call = 1;
    cycle(); reset = 0; call = 0; pc_sel = 0;
    check("rst_redir_pc", pc, 32'h0);
    check("rst_redir_mis", 32'(misalign), 32'h0);
    check("rst_redir_bad", bad_addr, 32'h0);
    check("rst_redir_empty", 32'(ras_empty), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Registered program-counter generator for the RISC-V core. Replaces the combinational PC+4 / ALU-target select.
- Selects the next fetch address with a fixed priority: reset, trap, mret, ALU redirect, stall, return prediction, sequential.
- Contains a parametrised circular return-address stack (RAS) for call/return prediction.
- Flags misaligned redirect targets so the trap logic can raise an instruction-address-misaligned exception.

Parameters:
- XLEN, 32, PC and data width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- IALIGN, 4, instruction alignment in bytes (4 = RV32I; 2 = C-extension targets allowed). Only 2 or 4 are legal.
- RAS_DEPTH, 4, RAS entries; power of two, 2..16.

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous active-high reset
- i_stall  in  1  hold PC (pipeline/memory stall)
- i_trap  in  1  take trap this cycle
- i_trap_vec  in  XLEN  trap handler address (mtvec base)
- i_mret  in  1  return from trap
- i_mepc  in  XLEN  return address for mret
- i_pc_sel  in  1  redirect to ALU-computed branch/jump target
- i_alu_data  in  XLEN  redirect target
- i_call  in  1  current instruction is a call (jal/jalr, rd=x1/x5)
- i_ret  in  1  current instruction is a return (jalr x0, x1/x5, 0)
- o_pc  out  XLEN  current fetch PC (registered)
- o_pc_four  out  XLEN  o_pc + 4 (combinational, link value)
- o_misalign  out  1  one-cycle pulse: rejected misaligned redirect
- o_bad_addr  out  XLEN  captured misaligned target (mtval source)
- o_ras_empty  out  1  RAS holds no valid entries
- o_ras_full  out  1  RAS holds RAS_DEPTH entries

Behaviour:
- Reset is synchronous, at the rising edge with i_reset=1. It sets:
  - o_pc=RESET_VECTOR, o_misalign=0, o_bad_addr=0
  - RAS pointer=0, count=0, so o_ras_empty=1 and o_ras_full=0
  - All other inputs are ignored that cycle.
- Latency: every next-PC decision is visible on o_pc one clock after the inputs are sampled. o_pc_four tracks o_pc combinationally, mod 2^XLEN (wraps from 0xFFFF_FFFC to 0).
- Next-PC priority, highest first:
  1. i_trap: pc=i_trap_vec with bits [1:0] forced to 0.
  2. i_mret: pc=i_mepc with the low bits forced to IALIGN alignment.
  3. i_pc_sel:
     - Target aligned (IALIGN=4: [1:0]==0; IALIGN=2: [0]==0): pc=i_alu_data.
     - Target misaligned: pc holds, o_misalign=1 for exactly one cycle, o_bad_addr=i_alu_data. o_bad_addr then holds until the next misalign or reset.
  4. i_stall: pc holds.
  5. i_ret with RAS non-empty: pc=RAS top, then pop.
  6. Otherwise pc=pc+4.
- o_misalign clears the next cycle unless a new misaligned redirect occurs.
- RAS update rules:
  - The RAS is updated only when the cycle is not reset, trap, mret or stall.
  - On a cycle with i_pc_sel (aligned or not), i_call and i_ret still act on the RAS. The redirect wins only the PC selection.
  - Push (i_call): write o_pc_four to the top.
  - Pop (i_ret): read the top, decrement the pointer.
  - i_call and i_ret together: pop then push, so the top entry is replaced by o_pc_four and the count is unchanged.
  - Push when full: circular overwrite of the oldest entry; count stays at RAS_DEPTH, pointer wraps mod RAS_DEPTH.
  - Pop when empty: no pointer/count change; PC falls through to pc+4.
  - RAS contents are not cleared by reset; only the pointer and count reset.
- i_trap and i_mret together: trap wins, and mret is ignored entirely.

Test Plan:
- Reset sequence: assert i_reset for 2 cycles, then release with no other inputs → o_pc=0x0 during reset, then 0x4, 0x8, 0xC on successive cycles; o_ras_empty=1.
- Aligned redirect and stall: at o_pc=0x10, pulse i_pc_sel with i_alu_data=0x200 → o_pc=0x200 next cycle. Then i_stall for 3 cycles → o_pc stays 0x200, then 0x204.
- Misaligned target with IALIGN=4: at o_pc=0x40, i_pc_sel with i_alu_data=0x102 → o_pc=0x40, o_misalign=1 for one cycle, o_bad_addr=0x102. The next cycle, i_trap with i_trap_vec=0x1001 → o_pc=0x1000. Repeat with IALIGN=2 → o_pc=0x102, no misalign.
- Call/return: at o_pc=0x100, i_call with i_pc_sel to 0x300 → RAS top=0x104, o_pc=0x300. Later, i_ret with no redirect → o_pc=0x104, o_ras_empty=1. A second i_ret when empty → pc+4.
- RAS overflow with RAS_DEPTH=4: 5 calls from PCs 0x0,0x10,0x20,0x30,0x40 → o_ras_full=1. Then 4 returns yield 0x44,0x34,0x24,0x14, after which o_ras_empty=1.
- Simultaneous events: i_trap and i_mret together → o_pc=i_trap_vec. i_call and i_ret together at o_pc=0x80 with top 0x14 → top becomes 0x84, count unchanged. i_reset with i_pc_sel → o_pc=RESET_VECTOR.
